// File: rtl/vga_console_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vga_console_ctrl
// Purpose  : Text-console sequencer for the vgachargen character/color maps.
//            Takes a byte stream, writes cells at a hardware cursor, handles
//            CR/LF/BS, and runs the clear and scroll-up sweeps over the maps.
// Revision : 1.0 - initial release
// ============================================================================
module vga_console_ctrl #(
  parameter int         COLS      = 80,
  parameter int         ROWS      = 30,
  parameter int         ADDR_W    = $clog2(COLS*ROWS),
  parameter logic [7:0] BLANK_CH  = 8'h20,
  parameter logic [7:0] DEF_COLOR = 8'h0F
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    ch_valid_i,
  input  logic [7:0]              ch_data_i,
  input  logic [7:0]              ch_color_i,
  output logic                    ch_ready_o,
  input  logic                    clear_i,
  output logic                    busy_o,
  output logic [$clog2(COLS)-1:0] cursor_x_o,
  output logic [$clog2(ROWS)-1:0] cursor_y_o,
  output logic [ADDR_W-1:0]       map_addr_o,
  output logic [7:0]              map_ch_o,
  output logic [7:0]              map_col_o,
  output logic                    map_wen_o,
  input  logic [7:0]              map_ch_i,
  input  logic [7:0]              map_col_i
);

  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);

  localparam logic [XW-1:0]     X_LAST      = XW'(COLS-1);
  localparam logic [YW-1:0]     Y_LAST      = YW'(ROWS-1);
  localparam logic [ADDR_W-1:0] ROW_STRIDE  = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] SCROLL_LAST = ADDR_W'(COLS*(ROWS-1)-1);
  localparam logic [ADDR_W-1:0] FILL_BASE   = ADDR_W'(COLS*(ROWS-1));
  localparam logic [ADDR_W-1:0] FILL_LAST   = ADDR_W'(COLS-1);
  localparam logic [ADDR_W-1:0] CLEAR_LAST  = ADDR_W'(COLS*ROWS-1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PUT       = 3'd1,
    SCROLL_RD = 3'd2,
    SCROLL_WR = 3'd3,
    FILL      = 3'd4,
    CLEAR     = 3'd5
  } state_t;

  state_t            state, state_n;
  logic [XW-1:0]     cur_x, cur_x_n;
  logic [YW-1:0]     cur_y, cur_y_n;
  logic [ADDR_W-1:0] idx, idx_n;
  logic              clear_pend, clear_pend_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [7:0]        ch_q, ch_n;
  logic [7:0]        col_q, col_n;
  logic              wen_q, wen_n;

  logic              clear_req;
  logic [ADDR_W-1:0] cell_addr;

  // A clear request arriving this cycle already blocks the byte stream.
  assign clear_req  = clear_pend | clear_i;
  assign cell_addr  = ADDR_W'(cur_y) * ROW_STRIDE + ADDR_W'(cur_x);

  assign ch_ready_o = (state == IDLE) & ~clear_req;
  assign busy_o     = (state != IDLE);
  assign cursor_x_o = cur_x;
  assign cursor_y_o = cur_y;
  assign map_addr_o = addr_q;
  assign map_wen_o  = wen_q;
  // In the write half of a scroll pair the read data (valid this cycle)
  // goes straight back out as write data; otherwise data is registered.
  assign map_ch_o   = (state == SCROLL_WR) ? map_ch_i  : ch_q;
  assign map_col_o  = (state == SCROLL_WR) ? map_col_i : col_q;

  // State, cursor, sweep index and registered map port.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cur_x      <= '0;
      cur_y      <= '0;
      idx        <= '0;
      clear_pend <= 1'b0;
      addr_q     <= '0;
      ch_q       <= '0;
      col_q      <= '0;
      wen_q      <= 1'b0;
    end else begin
      state      <= state_n;
      cur_x      <= cur_x_n;
      cur_y      <= cur_y_n;
      idx        <= idx_n;
      clear_pend <= clear_pend_n;
      addr_q     <= addr_n;
      ch_q       <= ch_n;
      col_q      <= col_n;
      wen_q      <= wen_n;
    end
  end

  // Next-state logic; map outputs are computed for the state being entered.
  always_comb begin
    state_n      = state;
    cur_x_n      = cur_x;
    cur_y_n      = cur_y;
    idx_n        = idx;
    clear_pend_n = clear_req;
    addr_n       = addr_q;
    ch_n         = ch_q;
    col_n        = col_q;
    wen_n        = 1'b0;

    unique case (state)
      IDLE: begin
        if (clear_req) begin
          state_n      = CLEAR;
          clear_pend_n = 1'b0;
          idx_n        = '0;
          addr_n       = '0;
          ch_n         = BLANK_CH;
          col_n        = DEF_COLOR;
          wen_n        = 1'b1;
        end else if (ch_valid_i) begin
          if (ch_data_i == 8'h0D) begin
            cur_x_n = '0;
          end else if (ch_data_i == 8'h0A) begin
            cur_x_n = '0;
            if (cur_y != Y_LAST) begin
              cur_y_n = cur_y + 1'b1;
            end else begin
              state_n = SCROLL_RD;
              idx_n   = '0;
              addr_n  = ROW_STRIDE;
            end
          end else if (ch_data_i == 8'h08) begin
            if (cur_x != '0) cur_x_n = cur_x - 1'b1;
          end else if (ch_data_i >= 8'h20) begin
            state_n = PUT;
            addr_n  = cell_addr;
            ch_n    = ch_data_i;
            col_n   = ch_color_i;
            wen_n   = 1'b1;
          end
        end
      end

      PUT: begin
        state_n = IDLE;
        if (cur_x != X_LAST) begin
          cur_x_n = cur_x + 1'b1;
        end else begin
          cur_x_n = '0;
          if (cur_y != Y_LAST) begin
            cur_y_n = cur_y + 1'b1;
          end else begin
            state_n = SCROLL_RD;
            idx_n   = '0;
            addr_n  = ROW_STRIDE;
          end
        end
      end

      SCROLL_RD: begin
        state_n = SCROLL_WR;
        addr_n  = idx;
        wen_n   = 1'b1;
      end

      SCROLL_WR: begin
        if (idx == SCROLL_LAST) begin
          state_n = FILL;
          idx_n   = '0;
          addr_n  = FILL_BASE;
          ch_n    = BLANK_CH;
          col_n   = DEF_COLOR;
          wen_n   = 1'b1;
        end else begin
          state_n = SCROLL_RD;
          idx_n   = idx + 1'b1;
          addr_n  = idx + 1'b1 + ROW_STRIDE;
        end
      end

      FILL: begin
        if (idx == FILL_LAST) begin
          state_n = IDLE;
          cur_x_n = '0;
          cur_y_n = Y_LAST;
        end else begin
          idx_n  = idx + 1'b1;
          addr_n = addr_q + 1'b1;
          wen_n  = 1'b1;
        end
      end

      CLEAR: begin
        if (idx == CLEAR_LAST) begin
          state_n = IDLE;
          cur_x_n = '0;
          cur_y_n = '0;
        end else begin
          idx_n  = idx + 1'b1;
          addr_n = addr_q + 1'b1;
          wen_n  = 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule
`default_nettype wire
